mux_rr_nto1: RTL and testbench
==============================

# mux_rr_nto1

Registered M-input, N-bit multiplexer with valid/ready handshaking on every channel and an output register stage. It generalises the combinational 2:1 select into a channel merger for the ALU datapath. In round-robin mode it arbitrates fairly among the requesting channels. In fixed mode it forwards one externally selected channel. Output latency is one cycle, and the block sustains full throughput under backpressure.

## Interface

**Parameters**
- `N`, default 32: data width of each channel and of the output.
- `M`, default 4: number of input channels. Legal range is M ≥ 2.
- `SW`, default `$clog2(M)`: width of the select and channel-index fields. Derived; never overridden.

**Ports**
- `clk` input, 1 bit: single clock. All state updates on the rising edge.
- `rst_n` input, 1 bit: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `in_data` input, M*N bits: flattened channel data. Channel c occupies `in_data[c*N +: N]`.
- `in_valid` input, M bits: per-channel request. Bit c asserts that channel c data is valid.
- `in_ready` output, M bits: per-channel accept. At most one bit is high in any cycle (one-hot or zero).
- `sel_mode` input, 1 bit: mode select. 0 = round-robin, 1 = fixed select.
- `sel` input, SW bits: channel index used in fixed mode.
- `out_data` output, N bits: registered output word.
- `out_valid` output, 1 bit: registered. High means `out_data` holds an unconsumed word.
- `out_ready` input, 1 bit: downstream accept.
- `out_sel` output, SW bits: registered. Index of the channel that supplied `out_data`.

## Operation

**Load enable**
- `load_en = !out_valid || out_ready`.
- This makes the output register a single-entry pipeline stage with pass-through ready.

**Grant, round-robin mode (`sel_mode` = 0)**
- Search channels in the order `ptr`, `ptr+1`, …, `ptr+M-1`, modulo M.
- The first channel with `in_valid` high wins.
- If no valid bit is set, there is no grant.

**Grant, fixed mode (`sel_mode` = 1)**
- The winner is `sel` if `in_valid[sel]` = 1.
- Otherwise there is no grant.
- If `sel` ≥ M (possible when M is not a power of 2), there is no grant.

**Handshake**
- `in_ready[w] = load_en && grant && (w == winner) && rst_n`.
- All other bits of `in_ready` are 0.
- A transfer on channel w occurs when `in_valid[w]` and `in_ready[w]` are both high.

**On a transfer (rising edge)**
- `out_data <= in_data[w*N +: N]`.
- `out_sel <= w`.
- `out_valid <= 1`.
- In round-robin mode only: `ptr <= (w == M-1) ? 0 : w+1`.

**On load_en with no grant**
- `out_valid <= 0`.
- `out_data` and `out_sel` hold their previous values.

**When load_en is low**
- `out_data`, `out_sel` and `out_valid` hold.
- `ptr` holds.

**Pointer behaviour**
- Fixed mode never modifies `ptr`.
- Switching back to round-robin resumes from the stored `ptr`.
- `sel_mode` and `sel` are combinational into the grant logic. A change applies to the same-cycle decision and never disturbs a word already held in the output register.

**Reset (`rst_n` = 0 at a rising edge)**
- `out_valid` = 0, `out_data` = 0, `out_sel` = 0, `ptr` = 0.
- `in_ready` is forced to all zeros while `rst_n` is low.
- Reset overrides any transfer or hold in the same cycle. A word held in the output register is discarded.

## Timing

**Latency and throughput**
- Latency: a word accepted at edge k appears on `out_data` with `out_valid` = 1 immediately after edge k. That is one cycle from acceptance.
- Throughput: one word per cycle when `out_ready` is held high.

**Combinational paths**
- `in_ready` depends combinationally on: `in_valid`, `sel_mode`, `sel`, `out_ready`, `out_valid`, `ptr`, `rst_n`.
- There is no combinational path from `in_data` to any output.

**Simultaneous events**
- Output consumed and new word loaded on the same edge: both occur; there is no bubble.
- All channels valid in round-robin mode: each channel is granted exactly once per M transfers.

**Downstream stall**
- With `out_ready` = 0 and `out_valid` = 1, `in_ready` = 0 on every channel.
- No word is lost or duplicated.

**Pointer wrap**
- A grant to channel M-1 sets `ptr` to 0.

## Test plan

1. **Reset.** Assert `rst_n` = 0 for 2 cycles with `in_valid` = 4'b1111 and `out_ready` = 1. Required: `out_valid` = 0, `out_data` = 0, `out_sel` = 0, `in_ready` = 4'b0000 throughout.
2. **Round-robin fairness.** M=4, N=32, all channels valid, channel c data = 0xC0+c, `out_ready` = 1, `sel_mode` = 0. Required on consecutive cycles: `out_data` = 0xC0, 0xC1, 0xC2, 0xC3, 0xC0 and `out_sel` = 0, 1, 2, 3, 0.
3. **Backpressure.** Drop `out_ready` to 0 after the first output word. Required: `out_data` holds 0xC0 and `in_ready` = 0 for every stalled cycle. When `out_ready` returns to 1, 0xC1 appears on the following cycle, with no loss and no duplicate.
4. **Fixed mode.** `sel_mode` = 1, `sel` = 2, `in_valid` = 4'b1111. Required: `in_ready` = 4'b0100 every cycle and `out_sel` = 2 continuously. Then clear `in_valid[2]`. Required: after the held word drains, `out_valid` = 0 and `in_ready` = 0.
5. **Sparse requests with wrap.** Round-robin mode, `ptr` = 2, `in_valid` = 4'b1010. Required grant sequence: channel 3, channel 1, channel 3 (`ptr` wraps 3→0 and skips channel 0).
6. **Mid-operation reset.** With `out_valid` = 1 and `out_ready` = 0, pulse `rst_n` = 0 for one cycle. Required: `out_valid` = 0 after that edge. Then, with all channels valid, the next grant is channel 0.

Source files
------------

// File: rtl/mux_rr_nto1_if.sv
// Channel-merger bus: M request channels in, one registered channel out.
interface mux_rr_nto1_if #(
  parameter int unsigned N = 32,
  parameter int unsigned M = 4
);
  localparam int unsigned SW = $clog2(M);

  logic [M*N-1:0] in_data;
  logic [M-1:0]   in_valid;
  logic [M-1:0]   in_ready;
  logic           sel_mode;
  logic [SW-1:0]  sel;
  logic [N-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;
  logic [SW-1:0]  out_sel;

  // Producer/consumer side: drives requests and downstream ready.
  modport master (
    output in_data, in_valid, sel_mode, sel, out_ready,
    input  in_ready, out_data, out_valid, out_sel
  );

  // Merger side.
  modport slave (
    input  in_data, in_valid, sel_mode, sel, out_ready,
    output in_ready, out_data, out_valid, out_sel
  );
endinterface

// File: rtl/mux_rr_nto1.sv
// Registered M:1 channel merger with valid/ready handshaking.
// Round-robin (sel_mode=0) or fixed-select (sel_mode=1) arbitration,
// one output register stage with pass-through ready.
module mux_rr_nto1 #(
  parameter int unsigned N  = 32,
  parameter int unsigned M  = 4,
  parameter int unsigned SW = $clog2(M)
) (
  input  logic          clk,
  input  logic          rst_n,
  mux_rr_nto1_if.slave  bus
);

  logic [SW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  out_data_q, out_data_d;
  logic [SW-1:0] out_sel_q, out_sel_d;
  logic          out_valid_q, out_valid_d;

  logic          load_en;
  logic          grant;
  logic [SW-1:0] winner;
  logic [N-1:0]  win_data;
  logic [M-1:0]  ready_vec;

  assign load_en = !out_valid_q || bus.out_ready;

  // Arbitration: fixed select, or rotating priority starting at ptr_q.
  always_comb begin
    grant  = 1'b0;
    winner = '0;
    if (bus.sel_mode) begin
      // sel >= M never matches a channel, so it yields no grant.
      for (int unsigned c = 0; c < M; c++) begin
        if (32'(bus.sel) == c && bus.in_valid[c]) begin
          grant  = 1'b1;
          winner = SW'(c);
        end
      end
    end else begin
      // Rotation split into two ascending scans: [ptr, M) then [0, ptr).
      for (int unsigned c = 0; c < M; c++) begin
        if (!grant && c >= 32'(ptr_q) && bus.in_valid[c]) begin
          grant  = 1'b1;
          winner = SW'(c);
        end
      end
      for (int unsigned c = 0; c < M; c++) begin
        if (!grant && c < 32'(ptr_q) && bus.in_valid[c]) begin
          grant  = 1'b1;
          winner = SW'(c);
        end
      end
    end
  end

  // Winner data select and one-hot ready generation.
  always_comb begin
    win_data  = '0;
    ready_vec = '0;
    for (int unsigned c = 0; c < M; c++) begin
      if (32'(winner) == c) begin
        win_data     = bus.in_data[c*N +: N];
        ready_vec[c] = load_en && grant && rst_n;
      end
    end
  end

  // Next-state for the output register and round-robin pointer.
  always_comb begin
    ptr_d       = ptr_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    if (load_en) begin
      if (grant) begin
        out_data_d  = win_data;
        out_sel_d   = winner;
        out_valid_d = 1'b1;
        if (!bus.sel_mode) begin
          ptr_d = (32'(winner) == M - 1) ? '0 : SW'(32'(winner) + 1);
        end
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = ready_vec;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_rr_nto1.sv
// Directed bench for mux_rr_nto1: a vector table for M=4 plus a short
// M=3 sequence covering out-of-range select and non-power-of-2 wrap.
module tb_mux_rr_nto1;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  mux_rr_nto1_if #(.N(32), .M(4)) bus4 ();
  mux_rr_nto1_if #(.N(8),  .M(3)) bus3 ();

  mux_rr_nto1 #(.N(32), .M(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4.slave)
  );

  mux_rr_nto1 #(.N(8), .M(3)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic [3:0]  valid;
    logic        ordy;
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  exp_ready;
    logic        exp_ov;
    logic [31:0] exp_od;
    logic [1:0]  exp_os;
  } vec_t;

  vec_t vecs [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic [3:0] v, input logic o,
                              input logic md, input logic [1:0] s, input logic [3:0] er,
                              input logic eov, input logic [31:0] eod, input logic [1:0] eos);
    vec_t t;
    t.rst_n = r; t.valid = v; t.ordy = o; t.mode = md; t.sel = s;
    t.exp_ready = er; t.exp_ov = eov; t.exp_od = eod; t.exp_os = eos;
    return t;
  endfunction

  // One cycle on the M=3 instance: drive, check ready pre-edge, check outputs post-edge.
  task automatic step3(input logic [2:0] v, input logic o, input logic md, input logic [1:0] s,
                       input logic [2:0] er, input logic eov, input logic [7:0] eod,
                       input logic [1:0] eos);
    bus3.in_valid  = v;
    bus3.out_ready = o;
    bus3.sel_mode  = md;
    bus3.sel       = s;
    #1;
    chk("m3_in_ready", 32'(bus3.in_ready), 32'(er));
    @(posedge clk); #1;
    chk("m3_out_valid", 32'(bus3.out_valid), 32'(eov));
    if (eov) chk("m3_out_data", 32'(bus3.out_data), 32'(eod));
    chk("m3_out_sel", 32'(bus3.out_sel), 32'(eos));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    for (int c = 0; c < 4; c++) bus4.in_data[c*32 +: 32] = 32'hC0 + 32'(c);
    bus4.in_valid = '0; bus4.out_ready = 1'b1; bus4.sel_mode = 1'b0; bus4.sel = '0;
    bus3.in_data  = {8'h32, 8'h31, 8'h30};
    bus3.in_valid = '0; bus3.out_ready = 1'b1; bus3.sel_mode = 1'b0; bus3.sel = '0;

    // rst, valid, ordy, mode, sel | in_ready, out_valid, out_data, out_sel
    // Reset held two cycles with all channels requesting.
    vecs.push_back(mk(0, 4'hF, 1, 0, 0, 4'b0000, 0, 32'h00, 0));
    vecs.push_back(mk(0, 4'hF, 1, 0, 0, 4'b0000, 0, 32'h00, 0));
    // Round-robin fairness.
    vecs.push_back(mk(1, 4'hF, 1, 0, 0, 4'b0001, 1, 32'hC0, 0));
    vecs.push_back(mk(1, 4'hF, 1, 0, 0, 4'b0010, 1, 32'hC1, 1));
    vecs.push_back(mk(1, 4'hF, 1, 0, 0, 4'b0100, 1, 32'hC2, 2));
    vecs.push_back(mk(1, 4'hF, 1, 0, 0, 4'b1000, 1, 32'hC3, 3));
    vecs.push_back(mk(1, 4'hF, 1, 0, 0, 4'b0001, 1, 32'hC0, 0));
    // Backpressure: hold C0, then C1 with no loss or duplicate.
    vecs.push_back(mk(1, 4'hF, 0, 0, 0, 4'b0000, 1, 32'hC0, 0));
    vecs.push_back(mk(1, 4'hF, 0, 0, 0, 4'b0000, 1, 32'hC0, 0));
    vecs.push_back(mk(1, 4'hF, 1, 0, 0, 4'b0010, 1, 32'hC1, 1));
    // Fixed mode on channel 2, then drop its request.
    vecs.push_back(mk(1, 4'hF, 1, 1, 2, 4'b0100, 1, 32'hC2, 2));
    vecs.push_back(mk(1, 4'hF, 1, 1, 2, 4'b0100, 1, 32'hC2, 2));
    vecs.push_back(mk(1, 4'hB, 1, 1, 2, 4'b0000, 0, 32'hC2, 2));
    vecs.push_back(mk(1, 4'hB, 1, 1, 2, 4'b0000, 0, 32'hC2, 2));
    // Sparse requests resuming from ptr=2: 3, 1, 3.
    vecs.push_back(mk(1, 4'hA, 1, 0, 0, 4'b1000, 1, 32'hC3, 3));
    vecs.push_back(mk(1, 4'hA, 1, 0, 0, 4'b0010, 1, 32'hC1, 1));
    vecs.push_back(mk(1, 4'hA, 1, 0, 0, 4'b1000, 1, 32'hC3, 3));
    // Move ptr to 1, stall, reset mid-operation, next grant is channel 0.
    vecs.push_back(mk(1, 4'hF, 1, 0, 0, 4'b0001, 1, 32'hC0, 0));
    vecs.push_back(mk(1, 4'hF, 0, 0, 0, 4'b0000, 1, 32'hC0, 0));
    vecs.push_back(mk(0, 4'hF, 0, 0, 0, 4'b0000, 0, 32'h00, 0));
    vecs.push_back(mk(1, 4'hF, 1, 0, 0, 4'b0001, 1, 32'hC0, 0));

    @(posedge clk); #1;
    foreach (vecs[i]) begin
      rst_n          = vecs[i].rst_n;
      bus4.in_valid  = vecs[i].valid;
      bus4.out_ready = vecs[i].ordy;
      bus4.sel_mode  = vecs[i].mode;
      bus4.sel       = vecs[i].sel;
      #1;
      chk($sformatf("v%0d_in_ready", i), 32'(bus4.in_ready), 32'(vecs[i].exp_ready));
      @(posedge clk); #1;
      chk($sformatf("v%0d_out_valid", i), 32'(bus4.out_valid), 32'(vecs[i].exp_ov));
      chk($sformatf("v%0d_out_data", i), bus4.out_data, vecs[i].exp_od);
      chk($sformatf("v%0d_out_sel", i), 32'(bus4.out_sel), 32'(vecs[i].exp_os));
    end
    bus4.in_valid = '0;

    // M=3: select index 3 is out of range, so no grant.
    step3(3'b111, 1, 1, 3, 3'b000, 0, 8'h00, 0);
    step3(3'b111, 1, 1, 2, 3'b100, 1, 8'h32, 2);
    // Round-robin from untouched ptr=0; grant to channel 2 must wrap ptr to 0.
    step3(3'b111, 1, 0, 0, 3'b001, 1, 8'h30, 0);
    step3(3'b111, 1, 0, 0, 3'b010, 1, 8'h31, 1);
    step3(3'b111, 1, 0, 0, 3'b100, 1, 8'h32, 2);
    step3(3'b111, 1, 0, 0, 3'b001, 1, 8'h30, 0);
    step3(3'b000, 1, 0, 0, 3'b000, 0, 8'h00, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
